// File: rtl/joybus_pkg.sv
// Shared state encoding and line-timing constants for the Joybus transaction controller.
// Timing constants are in microsecond units; the bit timer scales them to clock cycles.
package joybus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TX_LOW    = 3'd1,
        ST_TX_HIGH   = 3'd2,
        ST_STOP_LOW  = 3'd3,
        ST_STOP_HIGH = 3'd4,
        ST_RX        = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    localparam int UNIT_W = 2;

    localparam logic [UNIT_W-1:0] ZERO_LOW_US  = 2'd3;
    localparam logic [UNIT_W-1:0] ZERO_HIGH_US = 2'd1;
    localparam logic [UNIT_W-1:0] ONE_LOW_US   = 2'd1;
    localparam logic [UNIT_W-1:0] ONE_HIGH_US  = 2'd3;
    localparam logic [UNIT_W-1:0] STOP_LOW_US  = 2'd1;
    localparam logic [UNIT_W-1:0] STOP_HIGH_US = 2'd2;
    localparam logic [UNIT_W-1:0] UNIT_ONE     = 2'd1;

    localparam logic [2:0] MAX_RX_BYTES = 3'd4;

    function automatic logic [UNIT_W-1:0] low_units(input logic b);
        logic [UNIT_W-1:0] u;
        if (b) u = ONE_LOW_US;
        else   u = ZERO_LOW_US;
        return u;
    endfunction

    function automatic logic [UNIT_W-1:0] high_units(input logic b);
        logic [UNIT_W-1:0] u;
        if (b) u = ONE_HIGH_US;
        else   u = ZERO_HIGH_US;
        return u;
    endfunction

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        logic [2:0] l;
        if (len > MAX_RX_BYTES) l = MAX_RX_BYTES;
        else                    l = len;
        return l;
    endfunction

endpackage

// File: rtl/joybus_bit_timer.sv
// Microsecond prescaler plus down-counter of loaded us units; expire marks the last cycle
// of the loaded interval so the controller can switch phase on that same edge.
module joybus_bit_timer
    import joybus_pkg::*;
#(
    parameter int CLK_PER_US = 4
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [UNIT_W-1:0] units,
    output logic              expire
);

    localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_US - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0]  pre_r;
    logic [UNIT_W-1:0] units_r;
    logic              active_r;
    logic              tick_s;

    assign tick_s = active_r && (pre_r == PRE_MAX);
    assign expire = tick_s && (units_r == UNIT_ONE);

    // Prescale clk to us ticks and count the loaded units down to expiry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_r    <= '0;
            units_r  <= '0;
            active_r <= 1'b0;
        end else if (load) begin
            pre_r    <= '0;
            units_r  <= units;
            active_r <= 1'b1;
        end else if (tick_s) begin
            pre_r    <= '0;
            units_r  <= units_r - UNIT_ONE;
            active_r <= !expire;
        end else if (active_r) begin
            pre_r    <= pre_r + PRE_ONE;
        end else begin
            pre_r    <= pre_r;
        end
    end

endmodule

// File: rtl/joybus_txn_ctrl.sv
// Joybus host transaction controller: sends one command byte with pulse-width bit coding,
// a stop bit, then collects up to four response bytes from the line decoder.
module joybus_txn_ctrl
    import joybus_pkg::*;
#(
    parameter int CLK_PER_US = 4,
    parameter int TIMEOUT_US = 100
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  cmd_byte,
    input  logic [2:0]  rx_len,
    input  logic        rx_bit,
    input  logic        rx_valid,
    output logic        line_oe,
    output logic        dec_reset,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] rx_data,
    output logic [2:0]  rx_count
);

    localparam int SIL_CYCLES = TIMEOUT_US * CLK_PER_US;
    localparam int SIL_W      = $clog2(SIL_CYCLES + 1);
    localparam logic [SIL_W-1:0] SIL_LAST = SIL_W'(SIL_CYCLES - 1);
    localparam logic [SIL_W-1:0] SIL_ONE  = SIL_W'(1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        cmd_r;
    logic [2:0]        bit_idx_r;
    logic [2:0]        len_r;
    logic [5:0]        bits_r;
    logic [5:0]        bits_inc_s;
    logic [SIL_W-1:0]  silence_r;
    logic              tmr_load_s;
    logic [UNIT_W-1:0] tmr_units_s;
    logic              tmr_expire_s;
    logic              accept_s;
    logic              last_bit_s;
    logic              sil_expire_s;

    assign bits_inc_s   = bits_r + 6'd1;
    assign accept_s     = (state_r == ST_RX) && rx_valid;
    assign last_bit_s   = accept_s && (bits_inc_s == {len_r, 3'b000});
    // An accepted bit always wins over a silence expiry in the same cycle.
    assign sil_expire_s = (state_r == ST_RX) && !rx_valid && (silence_r == SIL_LAST);

    joybus_bit_timer #(
        .CLK_PER_US (CLK_PER_US)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load_s),
        .units   (tmr_units_s),
        .expire  (tmr_expire_s)
    );

    // Next-state and timer-load decode.
    always_comb begin
        state_nxt_s = state_r;
        tmr_load_s  = 1'b0;
        tmr_units_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_TX_LOW;
                    tmr_load_s  = 1'b1;
                    tmr_units_s = low_units(cmd_byte[7]);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TX_LOW: begin
                if (tmr_expire_s) begin
                    state_nxt_s = ST_TX_HIGH;
                    tmr_load_s  = 1'b1;
                    tmr_units_s = high_units(cmd_r[7]);
                end else begin
                    state_nxt_s = ST_TX_LOW;
                end
            end
            ST_TX_HIGH: begin
                if (tmr_expire_s && (bit_idx_r == 3'd0)) begin
                    state_nxt_s = ST_STOP_LOW;
                    tmr_load_s  = 1'b1;
                    tmr_units_s = STOP_LOW_US;
                end else if (tmr_expire_s) begin
                    state_nxt_s = ST_TX_LOW;
                    tmr_load_s  = 1'b1;
                    tmr_units_s = low_units(cmd_r[6]);
                end else begin
                    state_nxt_s = ST_TX_HIGH;
                end
            end
            ST_STOP_LOW: begin
                if (tmr_expire_s) begin
                    state_nxt_s = ST_STOP_HIGH;
                    tmr_load_s  = 1'b1;
                    tmr_units_s = STOP_HIGH_US;
                end else begin
                    state_nxt_s = ST_STOP_LOW;
                end
            end
            ST_STOP_HIGH: begin
                if (tmr_expire_s && (len_r == 3'd0)) begin
                    state_nxt_s = ST_FINISH;
                end else if (tmr_expire_s) begin
                    state_nxt_s = ST_RX;
                end else begin
                    state_nxt_s = ST_STOP_HIGH;
                end
            end
            ST_RX: begin
                if (last_bit_s) begin
                    state_nxt_s = ST_FINISH;
                end else if (sil_expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RX;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            line_oe   <= 1'b0;
            dec_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            line_oe   <= (state_nxt_s == ST_TX_LOW) || (state_nxt_s == ST_STOP_LOW);
            dec_reset <= (state_nxt_s != ST_RX);
            busy      <= (state_nxt_s != ST_IDLE);
            done      <= (state_nxt_s == ST_FINISH);
            timeout   <= sil_expire_s;
        end
    end

    // Command shifter, receive shifter and silence counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_r     <= '0;
            bit_idx_r <= '0;
            len_r     <= '0;
            bits_r    <= '0;
            silence_r <= '0;
            rx_data   <= '0;
            rx_count  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cmd_r     <= cmd_byte;
                        len_r     <= clamp_len(rx_len);
                        bit_idx_r <= 3'd7;
                        bits_r    <= '0;
                        silence_r <= '0;
                        rx_data   <= '0;
                        rx_count  <= '0;
                    end
                end
                ST_TX_HIGH: begin
                    if (tmr_expire_s) begin
                        cmd_r     <= {cmd_r[6:0], 1'b0};
                        bit_idx_r <= bit_idx_r - 3'd1;
                    end
                end
                ST_RX: begin
                    if (rx_valid) begin
                        rx_data   <= {rx_data[30:0], rx_bit};
                        bits_r    <= bits_inc_s;
                        rx_count  <= bits_inc_s[5:3];
                        silence_r <= '0;
                    end else begin
                        silence_r <= silence_r + SIL_ONE;
                    end
                end
                default: begin
                    cmd_r <= cmd_r;
                end
            endcase
        end
    end

endmodule

// File: doc/joybus_txn_ctrl.md
JOYBUS_TXN_CTRL -- requirements
Module: joybus_txn_ctrl

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 4: clk cycles per 1 us line-timing unit.
REQ-002 SHALL have parameter TIMEOUT_US, default 100: max us of silence in RX before abort.
REQ-003 SHALL have port clk  in  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  request a transaction; sampled only in IDLE.
REQ-006 SHALL have port cmd_byte  in  8  command byte to transmit, MSB first; captured with start.
REQ-007 SHALL have port rx_len  in  3  expected response bytes; captured with start; values >4 clamp to 4.
REQ-008 SHALL have port rx_bit  in  1  decoded bit value from line decoder (already synchronous to clk).
REQ-009 SHALL have port rx_valid  in  1  one-cycle pulse: rx_bit is a new decoded bit.
REQ-010 SHALL have port line_oe  out  1  1 = pull data line low (open drain), 0 = release.
REQ-011 SHALL have port dec_reset  out  1  active-high reset to line decoder.
REQ-012 SHALL have port busy  out  1  high in every state except IDLE.
REQ-013 SHALL have port done  out  1  one-cycle pulse: transaction completed with all bytes received.
REQ-014 SHALL have port timeout  out  1  one-cycle pulse: RX aborted by silence.
REQ-015 SHALL have port rx_data  out  32  received bits, shifted in LSB-first position (left shift).
REQ-016 SHALL have port rx_count  out  3  number of complete bytes received.

Function
REQ-017 SHALL implement states IDLE, TX_LOW, TX_HIGH, STOP_LOW, STOP_HIGH, RX, FINISH.
REQ-018 IDLE + start: capture cmd_byte/rx_len, clear rx_data/rx_count, go TX_LOW next cycle; line_oe=1 from that cycle.
REQ-019 Bit timing SHALL be: '0' = 3 us low + 1 us high; '1' = 1 us low + 3 us high (us = CLK_PER_US cycles).
REQ-020 TX_LOW->TX_HIGH after low time; TX_HIGH->TX_LOW for next bit, or ->STOP_LOW after bit 0 (8 bits, MSB first).
REQ-021 Stop bit SHALL be 1 us low (STOP_LOW) + 2 us high (STOP_HIGH).
REQ-022 dec_reset SHALL be 1 in IDLE, TX_*, STOP_*; 0 only in RX.
REQ-023 After STOP_HIGH: rx_len==0 -> FINISH; else -> RX.
REQ-024 In RX each rx_valid: rx_data <= {rx_data[30:0], rx_bit}; bit counter +1; rx_count = bits/8.
REQ-025 RX -> FINISH in the cycle the (8*rx_len)th bit is accepted.
REQ-026 FINISH: done=1 for exactly one cycle, then IDLE; rx_data/rx_count hold until next start.
REQ-027 RX silence counter SHALL reload on every rx_valid; reaching TIMEOUT_US*CLK_PER_US cycles -> timeout=1 one cycle, go IDLE; partial rx_data/rx_count retained.
REQ-028 start while busy SHALL be ignored; rx_valid outside RX SHALL be ignored.
REQ-029 rx_valid and timeout expiry in same cycle: bit accepted, counter reloads, no timeout.
REQ-030 line_oe SHALL be 0 in RX, FINISH, IDLE.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, line_oe=0, dec_reset=1, busy=0, done=0, timeout=0, rx_data=0, rx_count=0, all counters 0.
REQ-032 Reset mid-transaction SHALL abort with no done/timeout pulse; operation resumes on first start after release.

Structure
REQ-033 Package joybus_pkg SHALL hold the state encoding and us-unit constants (bit low/high units, stop units, max rx bytes=4).
REQ-034 One sub-module joybus_bit_timer SHALL generate us ticks and count down a loaded unit count, flagging expiry.

Verification (CLK_PER_US=4)
REQ-035 cmd 0x00, rx_len=3: 8x(12 low, 4 high) then 4 low, 8 high; feed 24 bits 0x050002 -> rx_data=0x00050002, rx_count=3, done 1 cycle.
REQ-036 cmd 0xFF, rx_len=0: 8x(4 low, 12 high), stop, done one cycle after STOP_HIGH; dec_reset never low.
REQ-037 cmd 0x01, rx_len=4, no rx_valid -> timeout pulse exactly 400 cycles after RX entry, done never asserted.
REQ-038 reset_n low during TX_LOW of bit 5 -> line_oe 0 same cycle, busy 0; later start runs a full clean transaction.
REQ-039 start pulsed mid-RX and rx_valid pulsed in IDLE -> no state, rx_data or counter change.
